// File: rtl/cl_acc_if.sv
// cl_acc_if: operand/opcode request side and registered-result response side
// of the cl_acc bitwise accumulator, bundled so they travel as one port.
interface cl_acc_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       S;
   logic             acc_en;
   logic             clr;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             out_ready;
   logic             zero;
   logic [CNT_W-1:0] op_cnt;

   // Requester / consumer side
   modport master (
      output in_valid, a, b, S, acc_en, clr, out_ready,
      input  in_ready, out, out_valid, zero, op_cnt
   );

   // The accumulator block itself
   modport slave (
      input  in_valid, a, b, S, acc_en, clr, out_ready,
      output in_ready, out, out_valid, zero, op_cnt
   );
endinterface

// File: rtl/cl_acc.sv
// cl_acc: single-stage bitwise logic unit with an accumulator feedback path,
// a one-deep valid/ready output register, a zero flag and a saturating
// count of accepted operations.
module cl_acc #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic      clk,
   input  logic      reset,
   cl_acc_if.slave   bus
);

   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] r_acc;
   logic             r_vld;
   logic             r_zero;
   logic [CNT_W-1:0] r_cnt;

   logic [WIDTH-1:0] w_opa;
   logic [WIDTH-1:0] w_res;
   logic             w_in_ready;
   logic             w_accept;

   // The output register can take a new result when it is empty or being
   // drained this same cycle, which gives one result per cycle at full rate.
   assign w_in_ready = !r_vld | bus.out_ready;
   assign w_accept   = bus.in_valid & w_in_ready;

   // Operand A: accumulator feedback or port a; a concurrent clr makes the
   // feedback value read as zero so clear-and-operate happens in one step.
   always_comb begin
      w_opa = bus.a;
      if (bus.acc_en) begin
         w_opa = bus.clr ? '0 : r_acc;
      end
   end

   // Bitwise opcode decode; purely per-bit, so no carry or extension exists.
   always_comb begin
      w_res = '0;
      case (bus.S)
         3'b000:  w_res = w_opa & bus.b;
         3'b001:  w_res = w_opa | bus.b;
         3'b010:  w_res = w_opa ^ bus.b;
         3'b011:  w_res = ~w_opa;
         3'b100:  w_res = ~(w_opa & bus.b);
         3'b101:  w_res = ~(w_opa | bus.b);
         3'b110:  w_res = ~(w_opa ^ bus.b);
         default: w_res = bus.b;
      endcase
   end

   // Result register, zero flag and valid: load on accept, drop valid once
   // consumed (value kept), otherwise hold while the consumer stalls.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out  <= '0;
         r_zero <= 1'b1;
         r_vld  <= 1'b0;
      end else if (w_accept) begin
         r_out  <= w_res;
         r_zero <= (w_res == '0);
         r_vld  <= 1'b1;
      end else if (bus.out_ready) begin
         r_vld  <= 1'b0;
      end
   end

   // Accumulator: a result load takes priority over a stand-alone clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc <= '0;
      end else if (w_accept) begin
         r_acc <= w_res;
      end else if (bus.clr) begin
         r_acc <= '0;
      end
   end

   // Accepted-operation counter; sticks at all-ones instead of wrapping and
   // is deliberately untouched by clr.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (w_accept && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out       = r_out;
   assign bus.out_valid = r_vld;
   assign bus.zero      = r_zero;
   assign bus.op_cnt    = r_cnt;

endmodule

// File: tb/tb_cl_acc.sv
// tb_cl_acc: directed vectors for cl_acc; stimulus pushes expected results
// into a scoreboard queue, a negedge monitor pops and compares on consume.
module tb_cl_acc;

   typedef struct packed {
      logic [7:0] out;
      logic       zero;
      logic [7:0] cnt;
   } exp_t;

   logic clk;
   logic reset;

   cl_acc_if #(.WIDTH(8), .CNT_W(8)) bus  ();
   cl_acc_if #(.WIDTH(8), .CNT_W(2)) bus2 ();

   cl_acc #(.WIDTH(8), .CNT_W(8)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
   cl_acc #(.WIDTH(8), .CNT_W(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

   exp_t sb[$];
   int   n_vec;
   int   n_err;
   int   exp_cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Scoreboard monitor: every consumed result must match the oldest expectation.
   always @(negedge clk) begin
      if (reset && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_underflow: got out=0x%0h, expected nothing pending", bus.out);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_out",  int'(bus.out),    int'(e.out));
            chk("sb_zero", int'(bus.zero),   int'(e.zero));
            chk("sb_cnt",  int'(bus.op_cnt), int'(e.cnt));
         end
      end
   end

   // Present an operation (called just after a rising edge), wait for it to
   // be accepted, then confirm the result is registered one edge later.
   task automatic op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s,
                     input logic ae, input logic cl, input logic [7:0] res);
      int   guard;
      exp_t e;
      bus.a = a; bus.b = b; bus.S = s; bus.acc_en = ae; bus.clr = cl;
      bus.in_valid = 1'b1;
      #1;
      guard = 0;
      while (!bus.in_ready && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 20) begin
         n_vec++; n_err++;
         $display("FAIL accept_timeout: got in_ready=0, expected 1");
      end
      if (exp_cnt < 255) exp_cnt++;
      e.out = res; e.zero = (res == 8'h00); e.cnt = 8'(exp_cnt);
      sb.push_back(e);
      @(posedge clk); #1;
      chk("lat_valid", int'(bus.out_valid), 1);
      chk("lat_out",   int'(bus.out),       int'(res));
   endtask

   task automatic idle();
      bus.in_valid = 1'b0; bus.clr = 1'b0;
      @(posedge clk); #1;
   endtask

   localparam logic [7:0] SWEEP [8] = '{8'h30, 8'hFC, 8'hCC, 8'h0F, 8'hCF, 8'h03, 8'h33, 8'h3C};
   localparam int         SAT   [5] = '{1, 2, 3, 3, 3};

   initial begin
      n_vec = 0; n_err = 0; exp_cnt = 0;
      reset = 1'b0;
      bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.S = 0; bus.acc_en = 0; bus.clr = 0;
      bus.out_ready = 1'b1;
      bus2.in_valid = 0; bus2.a = 0; bus2.b = 0; bus2.S = 0; bus2.acc_en = 0; bus2.clr = 0;
      bus2.out_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #2;
      chk("rst_out",   int'(bus.out),       0);
      chk("rst_valid", int'(bus.out_valid), 0);
      chk("rst_zero",  int'(bus.zero),      1);
      chk("rst_cnt",   int'(bus.op_cnt),    0);
      chk("rst_ready", int'(bus.in_ready),  1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;

      // Opcode sweep a=F0 b=3C, back to back
      for (int i = 0; i < 8; i++) op(8'hF0, 8'h3C, 3'(i), 1'b0, 1'b0, SWEEP[i]);
      idle();

      // Accumulator chain, then stand-alone clear
      op(8'h00, 8'hAA, 3'b111, 1'b0, 1'b0, 8'hAA);
      op(8'h00, 8'hFF, 3'b010, 1'b1, 1'b0, 8'h55);
      bus.in_valid = 1'b0; bus.clr = 1'b1;
      @(posedge clk); #1;
      bus.clr = 1'b0;
      chk("clr_out_hold",  int'(bus.out),  8'h55);
      chk("clr_zero_hold", int'(bus.zero), 0);
      op(8'hFF, 8'h00, 3'b001, 1'b1, 1'b0, 8'h00);

      // clr with accept: acc_en=1 uses zero operand, acc_en=0 load wins
      op(8'h12, 8'h00, 3'b011, 1'b1, 1'b1, 8'hFF);
      op(8'h00, 8'h0F, 3'b000, 1'b1, 1'b0, 8'h0F);
      op(8'h5A, 8'h5A, 3'b111, 1'b0, 1'b1, 8'h5A);
      op(8'h00, 8'h00, 3'b001, 1'b1, 1'b0, 8'h5A);
      idle();

      // Backpressure: first result frozen for 3 cycles, second waits
      bus.out_ready = 1'b0;
      op(8'h12, 8'h34, 3'b001, 1'b0, 1'b0, 8'h36);
      bus.a = 8'h12; bus.b = 8'h34; bus.S = 3'b010; bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_ready", int'(bus.in_ready), 0);
         chk("stall_out",   int'(bus.out),      8'h36);
         chk("stall_cnt",   int'(bus.op_cnt),   exp_cnt);
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      op(8'h12, 8'h34, 3'b010, 1'b0, 1'b0, 8'h26);
      idle();

      // Asynchronous reset while a result is pending
      bus.out_ready = 1'b0;
      op(8'h0F, 8'hF0, 3'b001, 1'b0, 1'b0, 8'hFF);
      bus.in_valid = 1'b0;
      @(negedge clk); #1;
      reset = 1'b0;
      #1;
      chk("arst_out",   int'(bus.out),       0);
      chk("arst_valid", int'(bus.out_valid), 0);
      chk("arst_zero",  int'(bus.zero),      1);
      chk("arst_cnt",   int'(bus.op_cnt),    0);
      chk("arst_ready", int'(bus.in_ready),  1);
      sb.delete();
      exp_cnt = 0;
      #1;
      reset = 1'b1;
      bus.out_ready = 1'b1;
      op(8'h81, 8'h0F, 3'b000, 1'b0, 1'b0, 8'h01);
      idle();

      // Saturation on the 2-bit counter instance
      bus2.S = 3'b111; bus2.b = 8'h11; bus2.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("sat_cnt", int'(bus2.op_cnt), SAT[i]);
      end
      bus2.in_valid = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cl_acc.md
CL_ACC -- requirements
Module: cl_acc

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, setting the operand, accumulator and result width in bits.
REQ-002 The module SHALL have parameter CNT_W, default 8, setting the operation-counter width in bits.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  operand/opcode presented.
REQ-006 Port in_ready  output  1  block can accept an operation this cycle.
REQ-007 Port a  input  WIDTH  operand A.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port S  input  3  opcode.
REQ-010 Port acc_en  input  1  when 1, the accumulator replaces operand A.
REQ-011 Port clr  input  1  synchronous accumulator clear.
REQ-012 Port out  output  WIDTH  registered result.
REQ-013 Port out_valid  output  1  out holds an unconsumed result.
REQ-014 Port out_ready  input  1  downstream consumes the result.
REQ-015 Port zero  output  1  registered flag; 1 when the registered result is all zeros.
REQ-016 Port op_cnt  output  CNT_W  count of accepted operations, saturating.

Function
REQ-017 Opcodes SHALL be bitwise across WIDTH: 000 A&B, 001 A|B, 010 A^B, 011 ~A, 100 ~(A&B), 101 ~(A|B), 110 ~(A^B), 111 B.
REQ-018 Operand A SHALL be the accumulator register when acc_en=1, otherwise port a.
REQ-019 An operation SHALL be accepted in a cycle where in_valid=1 and in_ready=1.
REQ-020 in_ready SHALL be combinational: !out_valid | out_ready.
REQ-021 On accept, at the next rising edge: out, zero and accumulator SHALL load the result, and out_valid SHALL be set to 1; latency is 1 cycle.
REQ-022 When out_valid=1 and out_ready=0, out, zero, out_valid and accumulator SHALL hold; a, b, S and acc_en are ignored.
REQ-023 When out_valid=1, out_ready=1 and no accept occurs in that cycle, out_valid SHALL clear at the next edge and out SHALL hold its value.
REQ-024 Simultaneous consume and accept SHALL reload out with out_valid staying 1, sustaining one result per cycle.
REQ-025 clr=1 with no accept SHALL zero the accumulator at the next edge and SHALL leave out, zero and out_valid unchanged.
REQ-026 clr=1 with an accept and acc_en=1 SHALL use 0 as operand A, and the accumulator SHALL load that result.
REQ-027 clr=1 with an accept and acc_en=0 SHALL let the accumulator load the result, so the load wins over clr.
REQ-028 op_cnt SHALL increment by 1 per accept and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-029 clr SHALL NOT affect op_cnt.
REQ-030 Results wider than WIDTH do not arise; no carry and no sign extension SHALL exist.

Reset
REQ-031 reset=0 SHALL immediately force out=0, accumulator=0, out_valid=0, op_cnt=0 and zero=1, independent of clk.
REQ-032 in_ready SHALL be 1 while reset=0.
REQ-033 Accepts SHALL be blocked while reset=0.
REQ-034 reset asserted mid-operation SHALL discard the pending result.
REQ-035 The first accept SHALL be honoured at the first rising edge after reset deasserts.

Verification
REQ-036 WIDTH=8, acc_en=0, out_ready=1, a=0xF0, b=0x3C, S swept 000..111 -> out sequence 0x30, 0xFC, 0xCC, 0x0F, 0xCF, 0x03, 0x33, 0x3C, each 1 cycle after accept; zero=0 throughout.
REQ-037 S=111, b=0xAA, acc_en=0, then S=010, acc_en=1, b=0xFF -> second out=0x55; then clr alone followed by S=001, acc_en=1, b=0x00 -> out=0x00, zero=1.
REQ-038 out_ready held 0 for 3 cycles with in_valid=1 -> in_ready=0, out frozen at the first result, op_cnt=1; out_ready=1 -> next result on the following edge, op_cnt=2.
REQ-039 CNT_W=2 with 5 back-to-back accepts -> op_cnt reads 1, 2, 3, 3, 3.
REQ-040 reset pulsed low between clock edges while out_valid=1 -> out=0, out_valid=0, zero=1, op_cnt=0 asynchronously; the first post-reset accept produces a correct result 1 cycle later.
REQ-041 clr=1, acc_en=1, S=011 on an accept -> out=0xFF and accumulator=0xFF.
